// File: rtl/fifo_wr_arbiter_if.sv
// Bus between the producers, the FIFO write port and the FIFO read status. The arbiter uses slave.
// With FIFO_ARB_BURST_EN defined, req_last_i marks the final beat of a locked burst.
interface fifo_wr_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 8
);
   logic [N_REQ-1:0]    req_valid_i;
   logic [N_REQ*DW-1:0] req_data_i;
   logic [N_REQ-1:0]    req_ready_o;
`ifdef FIFO_ARB_BURST_EN
   logic [N_REQ-1:0]    req_last_i;
`endif
   logic                fifo_wr_en_o;
   logic [DW-1:0]       fifo_data_o;
   logic                fifo_rd_en_i;
   logic                fifo_empty_i;

`ifdef FIFO_ARB_BURST_EN
   modport slave (
      input  req_valid_i, req_data_i, req_last_i, fifo_rd_en_i, fifo_empty_i,
      output req_ready_o, fifo_wr_en_o, fifo_data_o
   );
   modport master (
      output req_valid_i, req_data_i, req_last_i, fifo_rd_en_i, fifo_empty_i,
      input  req_ready_o, fifo_wr_en_o, fifo_data_o
   );
`else
   modport slave (
      input  req_valid_i, req_data_i, fifo_rd_en_i, fifo_empty_i,
      output req_ready_o, fifo_wr_en_o, fifo_data_o
   );
   modport master (
      output req_valid_i, req_data_i, fifo_rd_en_i, fifo_empty_i,
      input  req_ready_o, fifo_wr_en_o, fifo_data_o
   );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-tracked write arbiter in front of a synchronous FIFO.
// Optional FIFO_ARB_BURST_EN locks the grant to one owner until its req_last_i beat.
module fifo_wr_arbiter #(
   parameter int unsigned  N_REQ = 4,
   parameter int unsigned  DW    = 8,
   parameter int unsigned  DEPTH = 8,
   localparam int unsigned CW    = $clog2(DEPTH + 1),
   localparam int unsigned GW    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   fifo_wr_arbiter_if.slave        bus_io,
   output logic [CW-1:0]           credit_o,
   output logic [GW-1:0]           grant_idx_o
);

   logic              wr_en_q;
   logic [DW-1:0]     data_q,   data_d;
   logic [CW-1:0]     credit_q, credit_d;
   logic [GW-1:0]     grant_q,  grant_d;

   logic              ready_ok;
   logic              win_found;
   logic [GW-1:0]     win_idx;
   logic [GW:0]       cand_sum;
   logic              hs;
   logic              ret;

`ifdef FIFO_ARB_BURST_EN
   typedef enum logic {StArb, StLock} state_e;
   state_e state_q, state_d;
`endif

   // Ready is held low during reset even though the credit register already reads DEPTH.
   assign ready_ok = rst_n && (credit_q != '0);
   assign ret      = bus_io.fifo_rd_en_i && !bus_io.fifo_empty_i;
   assign hs       = ready_ok && win_found;

   always_comb begin
      win_found = 1'b0;
      win_idx   = grant_q;
      cand_sum  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand_sum = {1'b0, grant_q} + (GW+1)'(i);
         if (cand_sum >= (GW+1)'(N_REQ)) cand_sum = cand_sum - (GW+1)'(N_REQ);
         if (!win_found && bus_io.req_valid_i[cand_sum[GW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand_sum[GW-1:0];
         end
      end
`ifdef FIFO_ARB_BURST_EN
      // While locked, the owner (last granted index) is the only candidate.
      if (state_q == StLock) begin
         win_found = bus_io.req_valid_i[grant_q];
         win_idx   = grant_q;
      end
`endif
   end

   always_comb begin
      bus_io.req_ready_o = '0;
      if (hs) bus_io.req_ready_o = N_REQ'(1) << win_idx;
   end

   always_comb begin
      data_d   = data_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      if (hs) begin
         data_d  = bus_io.req_data_i[win_idx*DW +: DW];
         grant_d = win_idx;
      end
      // A return at full credit is a protocol error and is dropped.
      if (hs && !ret) begin
         credit_d = credit_q - CW'(1);
      end else if (ret && !hs && (credit_q != CW'(DEPTH))) begin
         credit_d = credit_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q  <= 1'b0;
         data_q   <= '0;
         credit_q <= CW'(DEPTH);
         grant_q  <= GW'(N_REQ - 1);
      end else begin
         wr_en_q  <= hs;
         data_q   <= data_d;
         credit_q <= credit_d;
         grant_q  <= grant_d;
      end
   end

`ifdef FIFO_ARB_BURST_EN
   always_comb begin
      state_d = state_q;
      if (hs) state_d = bus_io.req_last_i[win_idx] ? StArb : StLock;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StArb;
      else        state_q <= state_d;
   end
`endif

   assign bus_io.fifo_wr_en_o = wr_en_q;
   assign bus_io.fifo_data_o  = data_q;
   assign credit_o            = credit_q;
   assign grant_idx_o         = grant_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of an 8-bit synchronous FIFO among N_REQ producers.
- Each producer uses a valid/ready handshake.
- The block tracks FIFO free space with an internal credit counter, so it never issues a write into a full FIFO, even with a write in flight.
- It sits directly in front of the FIFO write port (wr_en/data) and observes the FIFO read strobe and empty flag to return credits.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width per requester and to the FIFO.
- DEPTH, 8, FIFO depth in words; initial credit value.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester data valid.
- req_data_i  in  N_REQ*DW  requester k data at bits [k*DW +: DW].
- req_ready_o  out  N_REQ  per-requester accept (one-hot or zero).
- fifo_wr_en_o  out  1  registered FIFO write strobe.
- fifo_data_o  out  DW  registered FIFO write data.
- fifo_rd_en_i  in  1  FIFO read strobe (same signal that drives the FIFO).
- fifo_empty_i  in  1  FIFO empty flag.
- credit_o  out  clog2(DEPTH+1)  current free-slot credit count.
- grant_idx_o  out  clog2(N_REQ)  index of last granted requester.

Behaviour:
- Reset (async, rst_n=0):
  - fifo_wr_en_o=0, fifo_data_o=0, credit_o=DEPTH.
  - grant_idx_o=N_REQ-1, so requester 0 has first priority.
  - req_ready_o=0 while in reset.
- Arbitration (combinational):
  - Search from grant_idx_o+1 upward, modulo N_REQ; the first k with req_valid_i[k]=1 wins.
  - req_ready_o[k]=1 only if credit_o>0; all other bits are 0.
  - If credit_o==0, req_ready_o is all zero regardless of valid.
- Handshake: when req_valid_i[k] && req_ready_o[k] at a rising edge:
  - next cycle fifo_wr_en_o=1 and fifo_data_o=req_data_i[k] (1-cycle latency);
  - grant_idx_o<=k.
- No handshake: fifo_wr_en_o=0 next cycle; fifo_data_o holds its last value.
- Credit counter, updated each edge:
  - handshake only: -1.
  - credit return only (fifo_rd_en_i && !fifo_empty_i): +1.
  - both: unchanged.
  - neither: unchanged.
- Credits are consumed at handshake, before the write lands, so credit_o never exceeds the true free space.
- A read with fifo_empty_i=1 returns no credit.
- credit_o saturates at DEPTH. A return that would exceed DEPTH is ignored; this is a protocol error for the bench to flag.
- Credit-limited case: with credit_o==1 and a same-cycle credit return, the handshake is still permitted (ready depends on the current credit only).
- Requester dropping valid: a requester may deassert valid without a handshake. The grant pointer does not move and no write is issued.
- Fairness: with all N_REQ requesters continuously valid and credit available, grants rotate 0,1,2,...,N_REQ-1,0,...
- Reset mid-operation: any pending registered write is discarded (fifo_wr_en_o forced to 0) and credit returns to DEPTH. The FIFO is reset by the same rst_n.

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- When defined:
  - Adds input req_last_i [N_REQ] and a two-state FSM: ARB and LOCK.
  - ARB: normal round-robin. A handshake with req_last_i[k]=0 moves to LOCK, holding owner k.
  - LOCK: only owner k may receive ready; other requesters are masked even if valid.
  - A handshake with req_last_i[k]=1 returns to ARB; grant_idx_o=k, so the next search starts at k+1.
  - credit_o==0 in LOCK stalls the owner without releasing the lock.
  - Reset returns to ARB.
- When undefined:
  - The port is absent, no FSM exists, and every beat is arbitrated independently.

Test Plan:
- Reset release, req_valid_i=4'b0001, data0=8'hA5 -> ready_o=4'b0001 in the same cycle; fifo_wr_en_o=1 with fifo_data_o=8'hA5 one cycle later; credit_o 8->7.
- All four requesters held valid with distinct data 8'h10..8'h13 and the FIFO not read -> writes in order 10,11,12,13,10,11,12,13; credit_o reaches 0 after 8 writes; req_ready_o then stays 4'b0000.
- From credit_o=0, pulse fifo_rd_en_i=1 with fifo_empty_i=0 for one cycle -> credit_o=1; next grant goes to requester 0 (last grant was 3).
- Simultaneous handshake and credit return at credit_o=3 -> credit_o stays 3. fifo_rd_en_i=1 with fifo_empty_i=1 -> credit_o unchanged.
- Assert rst_n=0 asynchronously mid-cycle while a handshake is pending -> fifo_wr_en_o drops immediately, credit_o=8, grant_idx_o=3; no stray write after release.
- With FIFO_ARB_BURST_EN, requester 1 sends a 3-beat burst (last on beat 3) while requesters 0 and 2 are valid -> three consecutive writes from requester 1; requester 2 is granted next, then requester 0.
